alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station and issue scheduler for the integer ALU. Buffers up to `DEPTH` dispatched ALU/branch/address operations, snoops the common data bus (CDB) to resolve pending source operands, and issues at most one operand-complete entry per cycle to the combinational ALU through registered issue outputs. Sits between the decoder/dispatch stage and the ALU; the ALU's result and ROB tag return on the CDB.

## Interface
- `DEPTH`, 8, number of entries; power of two, 2..16.
- `DATA_W`, 32, operand/data width.
- `TAG_W`, 4, ROB tag width.
- `OP_W`, 6, operation code width; code 0 is the idle/no-op encoding.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  misprediction flush; discards all entries.
- `in_valid`  in  1  dispatch request this cycle.
- `in_op`  in  OP_W  operation.
- `in_rob_tag`  in  TAG_W  destination ROB tag.
- `in_pc`, `in_imm`  in  DATA_W  instruction PC and immediate.
- `in_a_rdy`, `in_b_rdy`  in  1  source operand value present.
- `in_a_val`, `in_b_val`  in  DATA_W  operand value (used if rdy).
- `in_a_tag`, `in_b_tag`  in  TAG_W  producer ROB tag (used if not rdy).
- `full`  out  1  no free entry (registered state).
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  TAG_W  broadcast ROB tag.
- `cdb_data`  in  DATA_W  broadcast value.
- `alu_op`  out  OP_W  issued operation; 0 when idle.
- `alu_rob_tag`  out  TAG_W  issued ROB tag.
- `alu_pc`, `alu_a`, `alu_b`, `alu_imm`  out  DATA_W  issued PC, operands, immediate.

## Operation
- Per entry: `busy`, op, rob tag, pc, imm, and per operand {rdy, val, tag}.
- Dispatch: if `in_valid` and not `full`, write lowest-index non-busy entry; set busy. `in_valid` while `full` is dropped (upstream must stall on `full`); no state change.
- Dispatch bypass: if `cdb_valid` and an incoming not-ready operand's tag equals `cdb_tag` in the same cycle, entry is written with that operand ready and `val = cdb_data`.
- Wakeup: every busy entry with a not-ready operand whose tag equals `cdb_tag` while `cdb_valid` captures `cdb_data` and sets rdy. Both operands may wake on the same broadcast.
- Select: candidate = busy && a.rdy && b.rdy, evaluated on registered state. Lowest index wins. Winner's fields load into the issue registers; entry's busy clears at the same edge.
- No candidate: `alu_op` <= 0, `alu_rob_tag` <= 0; other issue outputs hold.
- Flush: at the edge with `flush`=1 all busy bits clear and `alu_op`/`alu_rob_tag` <= 0; flush has priority over dispatch, wakeup and issue that cycle.
- `full` = AND of all busy bits (registered state); an entry freed by issue is reusable from the following cycle.

## Timing
- Reset (async, `rst_n`=0): all busy cleared; `full`=0; all alu_* outputs 0.
- Dispatch at edge N with both operands ready -> issue registers load at edge N+1 (earliest).
- Wakeup at edge N -> entry eligible for selection in cycle after N; issue outputs load at edge N+1.
- Issue throughput: one per cycle; issue outputs valid for exactly one cycle per issued entry.
- Simultaneous dispatch and issue: both occur; dispatch target chosen from pre-edge busy bits, never the entry being issued.
- `rst_n` deassertion mid-stream: no entries survive; first dispatch after reset lands in entry 0.

## Test plan
- Reset: hold `rst_n`=0 two cycles -> `full`=0, `alu_op`=0, `alu_rob_tag`=0; release, dispatch ADD tag 3 A=5 B=7 both ready -> next cycle `alu_op`=ADD, `alu_rob_tag`=3, `alu_a`=5, `alu_b`=7, following cycle `alu_op`=0.
- Wakeup: dispatch tag 2 with A waiting on tag 9; no issue for 5 cycles; CDB {9, 0x40} -> one cycle later issue with `alu_a`=0x40.
- Bypass: dispatch A waiting on tag 6 in same cycle as CDB {6, 0x11} -> issued next cycle with `alu_a`=0x11.
- Full: dispatch 8 entries all waiting on tag 1 -> `full`=1, 9th `in_valid` ignored; CDB tag 1 -> entries issue in index order 0..7 on 8 consecutive cycles; `full` drops after first issue.
- Flush: 4 pending entries plus an issue in flight; assert `flush` -> next cycle `alu_op`=0, `full`=0, no further issues despite later matching CDB tags.
- Contention: dispatch into entry 0 while entry 1 issues and entry 2 wakes in the same cycle -> entry 1 issues this edge, then entries 0 and 2 issue on the next two cycles (0 first).

Source files
------------

// File: rtl/alu_rs.sv
// Integer ALU reservation station: buffers dispatched ops, snoops the CDB for
// operand wakeup, and issues the lowest-index operand-complete entry each cycle.
module alu_rs #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TAG_W-1:0]  in_rob_tag,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_a_rdy,
  input  logic              in_b_rdy,
  input  logic [DATA_W-1:0] in_a_val,
  input  logic [DATA_W-1:0] in_b_val,
  input  logic [TAG_W-1:0]  in_a_tag,
  input  logic [TAG_W-1:0]  in_b_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [OP_W-1:0]   alu_op,
  output logic [TAG_W-1:0]  alu_rob_tag,
  output logic [DATA_W-1:0] alu_pc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_imm
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic              a_rdy;
    logic [DATA_W-1:0] a_val;
    logic [TAG_W-1:0]  a_tag;
    logic              b_rdy;
    logic [DATA_W-1:0] b_val;
    logic [TAG_W-1:0]  b_tag;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t in_ent;

  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] cand_vec;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             alloc_found;
  logic [IDX_W-1:0] alloc_idx;
  logic             dispatch;

  logic [OP_W-1:0]   alu_op_q,  alu_op_d;
  logic [TAG_W-1:0]  alu_tag_q, alu_tag_d;
  logic [DATA_W-1:0] alu_pc_q,  alu_pc_d;
  logic [DATA_W-1:0] alu_a_q,   alu_a_d;
  logic [DATA_W-1:0] alu_b_q,   alu_b_d;
  logic [DATA_W-1:0] alu_imm_q, alu_imm_d;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_vec[i] = ent_q[i].busy;
      cand_vec[i] = ent_q[i].busy && ent_q[i].a_rdy && ent_q[i].b_rdy;
    end
  end

  assign full     = &busy_vec;
  assign dispatch = in_valid && alloc_found;

  // Both pickers look only at pre-edge state, so dispatch never lands on the entry issuing now.
  always_comb begin
    sel_found   = 1'b0;
    sel_idx     = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && cand_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!alloc_found && !busy_vec[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    in_ent       = '0;
    in_ent.busy  = 1'b1;
    in_ent.op    = in_op;
    in_ent.rob   = in_rob_tag;
    in_ent.pc    = in_pc;
    in_ent.imm   = in_imm;
    in_ent.a_tag = in_a_tag;
    in_ent.b_tag = in_b_tag;
    in_ent.a_rdy = in_a_rdy || (cdb_valid && (in_a_tag == cdb_tag));
    in_ent.b_rdy = in_b_rdy || (cdb_valid && (in_b_tag == cdb_tag));
    in_ent.a_val = in_a_rdy ? in_a_val : cdb_data;
    in_ent.b_val = in_b_rdy ? in_b_val : cdb_data;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && cdb_valid) begin
        if (!ent_q[i].a_rdy && (ent_q[i].a_tag == cdb_tag)) begin
          ent_d[i].a_rdy = 1'b1;
          ent_d[i].a_val = cdb_data;
        end
        if (!ent_q[i].b_rdy && (ent_q[i].b_tag == cdb_tag)) begin
          ent_d[i].b_rdy = 1'b1;
          ent_d[i].b_val = cdb_data;
        end
      end
      if (sel_found && (sel_idx == IDX_W'(i)))
        ent_d[i].busy = 1'b0;
      if (dispatch && (alloc_idx == IDX_W'(i)))
        ent_d[i] = in_ent;
      if (flush)
        ent_d[i].busy = 1'b0;
    end
  end

  always_comb begin
    alu_op_d  = '0;
    alu_tag_d = '0;
    alu_pc_d  = alu_pc_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_imm_d = alu_imm_q;
    if (!flush && sel_found) begin
      alu_op_d  = ent_q[sel_idx].op;
      alu_tag_d = ent_q[sel_idx].rob;
      alu_pc_d  = ent_q[sel_idx].pc;
      alu_a_d   = ent_q[sel_idx].a_val;
      alu_b_d   = ent_q[sel_idx].b_val;
      alu_imm_d = ent_q[sel_idx].imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
      alu_op_q  <= '0;
      alu_tag_q <= '0;
      alu_pc_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_imm_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
      alu_op_q  <= alu_op_d;
      alu_tag_q <= alu_tag_d;
      alu_pc_q  <= alu_pc_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_imm_q <= alu_imm_d;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_rob_tag = alu_tag_q;
  assign alu_pc      = alu_pc_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_imm     = alu_imm_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios with literal expectations plus random
// traffic, all outputs compared against a slot-list model every cycle.
module tb_alu_rs;
  localparam int DEPTH = 8;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int OW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, in_valid, in_a_rdy, in_b_rdy, cdb_valid, full;
  logic [OW-1:0] in_op, alu_op;
  logic [TW-1:0] in_rob_tag, in_a_tag, in_b_tag, cdb_tag, alu_rob_tag;
  logic [DW-1:0] in_pc, in_imm, in_a_val, in_b_val, cdb_data;
  logic [DW-1:0] alu_pc, alu_a, alu_b, alu_imm;

  alu_rs #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_op(in_op), .in_rob_tag(in_rob_tag), .in_pc(in_pc), .in_imm(in_imm),
    .in_a_rdy(in_a_rdy), .in_b_rdy(in_b_rdy), .in_a_val(in_a_val), .in_b_val(in_b_val),
    .in_a_tag(in_a_tag), .in_b_tag(in_b_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_op(alu_op), .alu_rob_tag(alu_rob_tag), .alu_pc(alu_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: slots hold pending instructions; the oldest-index ready slot issues.
  typedef struct {
    bit            busy;
    logic [OW-1:0] op;
    logic [TW-1:0] rob;
    logic [DW-1:0] pc, imm;
    bit            ardy, brdy;
    logic [DW-1:0] aval, bval;
    logic [TW-1:0] atag, btag;
  } slot_t;

  slot_t         m [DEPTH];
  logic [OW-1:0] e_op;
  logic [TW-1:0] e_tag;
  logic [DW-1:0] e_pc, e_a, e_b, e_imm;

  function automatic bit m_full();
    for (int i = 0; i < DEPTH; i++)
      if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
        e_op = '0; e_tag = '0; e_pc = '0; e_a = '0; e_b = '0; e_imm = '0;
      end else if (flush) begin
        for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
        e_op = '0; e_tag = '0;
      end else begin
        int win, fr;
        win = -1; fr = -1;
        for (int i = 0; i < DEPTH; i++) begin
          if (win < 0 && m[i].busy && m[i].ardy && m[i].brdy) win = i;
          if (fr < 0 && !m[i].busy) fr = i;
        end
        if (win >= 0) begin
          e_op = m[win].op; e_tag = m[win].rob; e_pc = m[win].pc;
          e_a = m[win].aval; e_b = m[win].bval; e_imm = m[win].imm;
          m[win].busy = 1'b0;
        end else begin
          e_op = '0; e_tag = '0;
        end
        if (cdb_valid)
          for (int i = 0; i < DEPTH; i++) begin
            if (m[i].busy && !m[i].ardy && m[i].atag == cdb_tag) begin m[i].ardy = 1; m[i].aval = cdb_data; end
            if (m[i].busy && !m[i].brdy && m[i].btag == cdb_tag) begin m[i].brdy = 1; m[i].bval = cdb_data; end
          end
        if (in_valid && fr >= 0) begin
          m[fr].busy = 1'b1; m[fr].op = in_op; m[fr].rob = in_rob_tag;
          m[fr].pc = in_pc; m[fr].imm = in_imm;
          m[fr].atag = in_a_tag; m[fr].btag = in_b_tag;
          m[fr].ardy = in_a_rdy; m[fr].aval = in_a_val;
          m[fr].brdy = in_b_rdy; m[fr].bval = in_b_val;
          if (!in_a_rdy && cdb_valid && in_a_tag == cdb_tag) begin m[fr].ardy = 1; m[fr].aval = cdb_data; end
          if (!in_b_rdy && cdb_valid && in_b_tag == cdb_tag) begin m[fr].brdy = 1; m[fr].bval = cdb_data; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("full", full, m_full());
        chk("alu_op", alu_op, e_op);
        chk("alu_rob_tag", alu_rob_tag, e_tag);
        chk("alu_pc", alu_pc, e_pc);
        chk("alu_a", alu_a, e_a);
        chk("alu_b", alu_b, e_b);
        chk("alu_imm", alu_imm, e_imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_valid = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic disp(input int op, input int rob, input bit ar, input int av, input int at,
                      input bit br, input int bv, input int bt);
    in_valid = 1; in_op = OW'(op); in_rob_tag = TW'(rob);
    in_pc = $urandom; in_imm = $urandom;
    in_a_rdy = ar; in_a_val = DW'(av); in_a_tag = TW'(at);
    in_b_rdy = br; in_b_val = DW'(bv); in_b_tag = TW'(bt);
  endtask

  task automatic cdb(input int tag, input int data);
    cdb_valid = 1; cdb_tag = TW'(tag); cdb_data = DW'(data);
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; cdb_valid = 0;
    in_op = '0; in_rob_tag = '0; in_pc = '0; in_imm = '0;
    in_a_rdy = 0; in_b_rdy = 0; in_a_val = '0; in_b_val = '0;
    in_a_tag = '0; in_b_tag = '0; cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    started = 1;
    chk("rst_full", full, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_tag", alu_rob_tag, 0);
    rst_n = 1;

    // first dispatch, both operands ready
    disp(1, 3, 1, 5, 0, 1, 7, 0);
    tick(); idle();
    tick();
    chk("add_op", alu_op, 1);
    chk("add_tag", alu_rob_tag, 3);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    tick();
    chk("add_idle", alu_op, 0);

    // wakeup of a waiting operand
    disp(2, 2, 0, 0, 9, 1, 3, 0);
    tick(); idle();
    for (int i = 0; i < 5; i++) begin tick(); chk("wake_wait", alu_op, 0); end
    cdb(9, 32'h40);
    tick(); idle();
    chk("wake_notyet", alu_op, 0);
    tick();
    chk("wake_op", alu_op, 2);
    chk("wake_tag", alu_rob_tag, 2);
    chk("wake_a", alu_a, 32'h40);
    tick();

    // same-cycle bypass on dispatch
    disp(3, 5, 0, 0, 6, 1, 1, 0);
    cdb(6, 32'h11);
    tick(); idle();
    tick();
    chk("byp_op", alu_op, 3);
    chk("byp_a", alu_a, 32'h11);
    tick();

    // fill all entries, drop the ninth, drain in index order
    for (int i = 0; i < DEPTH; i++) begin disp(4, i, 0, 0, 1, 1, 2, 0); tick(); end
    idle();
    chk("full_set", full, 1);
    disp(5, 15, 1, 1, 0, 1, 1, 0);
    tick(); idle();
    chk("full_hold", full, 1);
    cdb(1, 32'h99);
    tick(); idle();
    chk("full_noissue", alu_op, 0);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("drain_op", alu_op, 4);
      chk("drain_tag", alu_rob_tag, i);
      if (i == 0) chk("drain_full", full, 0);
    end
    tick();
    chk("drain_done", alu_op, 0);

    // flush with pending entries and one about to issue
    for (int i = 0; i < 4; i++) begin disp(6, 8 + i, 0, 0, 5, 1, 0, 0); tick(); end
    disp(7, 12, 1, 1, 0, 1, 1, 0);
    tick(); idle();
    flush = 1;
    tick(); flush = 0;
    chk("flush_op", alu_op, 0);
    chk("flush_full", full, 0);
    cdb(5, 32'h55);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin tick(); chk("flush_quiet", alu_op, 0); end

    // dispatch into entry 0 while entry 1 issues and entry 2 wakes
    disp(8, 1, 0, 0, 12, 1, 0, 0); tick();
    disp(8, 4, 0, 0, 8, 1, 0, 0); tick();
    disp(8, 5, 0, 0, 9, 1, 0, 0); tick();
    idle();
    cdb(12, 32'h12); tick();
    cdb(8, 32'h8); tick();
    chk("cont_e0", alu_rob_tag, 1);
    idle();
    cdb(9, 32'h9);
    disp(9, 6, 1, 3, 0, 1, 4, 0);
    tick(); idle();
    chk("cont_e1", alu_rob_tag, 4);
    tick();
    chk("cont_new_op", alu_op, 9);
    chk("cont_new_tag", alu_rob_tag, 6);
    tick();
    chk("cont_e2", alu_rob_tag, 5);
    tick();
    chk("cont_done", alu_op, 0);

    // random traffic, occasional flush and mid-stream reset
    for (int c = 0; c < 3000; c++) begin
      if (!rst_n) rst_n = 1;
      in_valid = ($urandom_range(0, 2) != 0);
      in_op = OW'($urandom_range(1, 63));
      in_rob_tag = TW'($urandom);
      in_pc = $urandom; in_imm = $urandom;
      in_a_rdy = $urandom_range(0, 1) != 0; in_a_val = $urandom; in_a_tag = TW'($urandom_range(0, 3));
      in_b_rdy = $urandom_range(0, 1) != 0; in_b_val = $urandom; in_b_tag = TW'($urandom_range(0, 3));
      cdb_valid = ($urandom_range(0, 2) == 0);
      cdb_tag = TW'($urandom_range(0, 3)); cdb_data = $urandom;
      flush = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) rst_n = 0;
      tick();
    end
    idle(); rst_n = 1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
